// File: rtl/core_dg_pkg.sv
// core_dg_pkg
//   Shared widths, packet layout and the Hamming(7,4) encoder used by the
//   transmit-side packetiser. Kept free of module-specific state so the
//   decoder side can import it for golden-model checks.
//   Codeword bit order: c0=P1 c1=P2 c2=D1 c3=P4 c4=D2 c5=D3 c6=D4.
package core_dg_pkg;

  localparam int DG_W   = 8;
  localparam int PKT_W  = 11;
  localparam int CW_W   = 7;
  localparam int IP_W   = 4;
  localparam int DATA_W = 4;

  // Router packet: | 7-bit codeword | 4-bit IP |
  typedef struct packed {
    logic [CW_W-1:0] cw;
    logic [IP_W-1:0] ip;
  } pkt_t;

  // d[0]=D1 .. d[3]=D4
  function automatic logic [CW_W-1:0] hamming74_encode(input logic [DATA_W-1:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

endpackage

// File: rtl/core_dg_fifo.sv
// core_dg_fifo
//   Synchronous FIFO, DEPTH entries (power of two, >= 2) of WIDTH bits.
//   Full/empty come from an occupancy counter, pointers wrap modulo DEPTH.
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset (empties FIFO)
//     push, din       write request and data (ignored when full)
//     pop             read request (ignored when empty)
//     full, empty     status, registered-state only
//     head            oldest entry, valid while !empty
module core_dg_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [OW-1:0]    occ;
  logic             do_push;
  logic             do_pop;

  assign full    = (occ == OW'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/core_dg_hamming_enc.sv
// core_dg_hamming_enc
//   Transmit-side Hamming(7,4) packetiser. Encodes the data nibble of each
//   accepted generator word, optionally corrupts one codeword bit every
//   ERR_PERIOD-th accept, and queues the packet in an output FIFO.
//   Ports:
//     clk, rst_n            clock, synchronous active-low reset
//     dg_valid/dg_ready     generator handshake; dg_data = {data[3:0], ip[3:0]}
//     pkt_valid/pkt_ready   router handshake;    pkt_data = {cw[6:0], ip[3:0]}
//     inject_en             enable periodic single-bit corruption
//     pkt_count             packets popped, wraps at 2^16
//     err_count             packets corrupted, saturates at 255
module core_dg_hamming_enc
  import core_dg_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int ERR_PERIOD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             dg_valid,
  output logic             dg_ready,
  input  logic [DG_W-1:0]  dg_data,
  output logic             pkt_valid,
  input  logic             pkt_ready,
  output logic [PKT_W-1:0] pkt_data,
  input  logic             inject_en,
  output logic [15:0]      pkt_count,
  output logic [7:0]       err_count
);

  localparam int PER_W = (ERR_PERIOD > 1) ? $clog2(ERR_PERIOD) : 1;

  logic             accept;
  logic             send;
  logic             fifo_full;
  logic             fifo_empty;
  logic             period_end;
  logic             inject_hit;
  logic [CW_W-1:0]  cw_clean;
  logic [CW_W-1:0]  flip_mask;
  pkt_t             enc_pkt;
  logic [PER_W-1:0] per_cnt;
  logic [2:0]       err_pos;

  assign dg_ready   = !fifo_full;
  assign pkt_valid  = !fifo_empty;
  assign accept     = dg_valid && dg_ready;
  assign send       = pkt_valid && pkt_ready;
  assign period_end = (per_cnt == PER_W'(ERR_PERIOD - 1));
  assign inject_hit = accept && inject_en && period_end;

  always_comb begin
    cw_clean   = hamming74_encode(dg_data[7:4]);
    flip_mask  = '0;
    if (inject_hit) flip_mask = CW_W'(1) << err_pos;
    enc_pkt.cw = cw_clean ^ flip_mask;
    enc_pkt.ip = dg_data[3:0];
  end

  core_dg_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .din   (enc_pkt),
    .pop   (send),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (pkt_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      per_cnt   <= '0;
      err_pos   <= '0;
      err_count <= '0;
      pkt_count <= '0;
    end else begin
      if (accept) per_cnt <= period_end ? '0 : per_cnt + PER_W'(1);
      if (inject_hit) begin
        err_pos <= (err_pos == 3'd6) ? '0 : err_pos + 3'd1;
        if (err_count != '1) err_count <= err_count + 8'd1;
      end
      if (send) pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule
